// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU unit:
//   - ALU_OP_W       : width of the operation code
//   - ALU_add..ALU_deactive : operation codes
//   - state_t        : handshake FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_add      = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_sub      = 3'd1;  // B - A
    localparam logic [ALU_OP_W-1:0] ALU_and      = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_or       = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_not      = 3'd4;  // ~A
    localparam logic [ALU_OP_W-1:0] ALU_slt      = 3'd5;  // signed A < B
    localparam logic [ALU_OP_W-1:0] ALU_mul      = 3'd6;  // unsigned, low half
    localparam logic [ALU_OP_W-1:0] ALU_deactive = 3'd7;  // result 0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Iterative shift-add unsigned multiplier, one partial-product step per cycle.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load          : start a new multiply (counter := WIDTH)
//   mcand, mplier : operands, captured on load
//   finish        : high during the cycle whose edge performs the last step
//   product_next  : 2*WIDTH product value that the current step produces;
//                   equals the full product while finish is high
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               finish,
    output logic [2*WIDTH-1:0] product_next
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;    // {accumulator, remaining multiplier bits}
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH:0]     add_sum;
    logic               stepping;

    assign stepping = (cnt_reg != '0);

    // Add the multiplicand into the upper half when the current LSB is set,
    // then shift the whole register right; the carry lands in the top bit.
    assign add_sum      = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                        + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    assign product_next = {add_sum, prod_reg[WIDTH-1:1]};
    assign finish       = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            prod_reg  <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            mcand_reg <= mcand;
            prod_reg  <= {{WIDTH{1'b0}}, mplier};
            cnt_reg   <= CNT_W'(WIDTH);
        end else if (stepping) begin
            prod_reg  <= product_next;
            cnt_reg   <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
// Registered ALU with start/done handshake. Single-cycle ops complete one
// edge after acceptance; multiply runs WIDTH steps in alu_mul_seq.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while ready=1
//   alu_op     : operation code (alu_pkg)
//   a, b       : operands, used at the accepting edge only
//   ready      : unit idle or just done, can accept start
//   done       : one-cycle pulse, result/flags updated
//   result     : registered result, held until next done
//   zero, neg  : result == 0, result MSB
//   carry      : adder carry-out (add/sub only)
//   ovf        : signed overflow (add/sub) or product truncation (mul)
// ---------------------------------------------------------------------------
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                ready,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                neg,
    output logic                carry,
    output logic                ovf
);

    state_t state_reg, state_next;

    logic               accept;
    logic               is_mul;
    logic               wr_alu;
    logic               wr_mul;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    logic               mul_finish;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   res_next;
    logic               carry_next;
    logic               ovf_next;

    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               neg_reg;
    logic               carry_reg;
    logic               ovf_reg;

    // ready depends on state only, so there is no start->ready path.
    assign ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign done   = (state_reg == ST_DONE);
    assign accept = start && ready;
    assign is_mul = (alu_op == ALU_mul);
    assign wr_alu = accept && !is_mul;
    assign wr_mul = (state_reg == ST_BUSY) && mul_finish;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = is_mul ? ST_BUSY : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // start is not looked at here: requests while busy are dropped
                if (mul_finish) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    assign add_sum = {1'b0, a} + {1'b0, b};
    // Subtraction is B - A, done as B + ~A + 1 so carry means "no borrow".
    assign sub_sum = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op)
            ALU_add: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1])
                         && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_sub: begin
                alu_res   = sub_sum[WIDTH-1:0];
                alu_carry = sub_sum[WIDTH];
                // adder operands are b and ~a
                alu_ovf   = (b[WIDTH-1] != a[WIDTH-1])
                         && (sub_sum[WIDTH-1] != b[WIDTH-1]);
            end
            ALU_and: alu_res = a & b;
            ALU_or:  alu_res = a | b;
            ALU_not: alu_res = ~a;
            ALU_slt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;  // mul handled by alu_mul_seq; deactive is 0
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    alu_mul_seq #(
        .WIDTH        (WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (accept && is_mul),
        .mcand        (a),
        .mplier       (b),
        .finish       (mul_finish),
        .product_next (mul_product)
    );

    // ------------------------------------------------------------------
    // Result / flag registers, written only on the edge entering DONE
    // ------------------------------------------------------------------
    always_comb begin
        res_next   = alu_res;
        carry_next = alu_carry;
        ovf_next   = alu_ovf;
        if (wr_mul) begin
            res_next   = mul_product[WIDTH-1:0];
            carry_next = 1'b0;
            ovf_next   = |mul_product[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (wr_alu || wr_mul) begin
            result_reg <= res_next;
            zero_reg   <= (res_next == '0);
            neg_reg    <= res_next[WIDTH-1];
            carry_reg  <= carry_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign result = result_reg;
    assign zero   = zero_reg;
    assign neg    = neg_reg;
    assign carry  = carry_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
// Scoreboard bench for alu_seq_unit (WIDTH=16). Each issued op pushes its
// expected result, flags {zero,neg,carry,ovf} and the negedge index at which
// done must appear; a negedge monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    alu_op = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready, done, zero, neg, carry, ovf;
    logic [W-1:0]  result;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   negcount = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_op (alu_op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .zero   (zero),
        .neg    (neg),
        .carry  (carry),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] done @%0d result=%h flags=%b", negcount, result, {zero, neg, carry, ovf});
                check_eq("result", {16'd0, result}, {16'd0, mon_e.res});
                check_eq("flags", {28'd0, zero, neg, carry, ovf}, {28'd0, mon_e.flg});
                check_eq("done_cycle", negcount, mon_e.at);
            end
        end
        negcount <= negcount + 1;
    end

    // Drive one request; off = negedges from issue until done is visible.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic [3:0] ef, input int off);
        exp_t e;
        @(negedge clk); #1;
        start  = 1'b1;
        alu_op = op;
        a      = av;
        b      = bv;
        e.res  = er;
        e.flg  = ef;
        e.at   = negcount + off;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_result"}, {16'd0, result}, 32'd0);
        check_eq({tag, "_flags"}, {28'd0, zero, neg, carry, ovf}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // add / sub with flag corners
        issue(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 0); drain();
        issue(3'd1, 16'h0005, 16'h0003, 16'hFFFE, 4'b0100, 0); drain();
        issue(3'd1, 16'h0003, 16'h0003, 16'h0000, 4'b1010, 0); drain();
        issue(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 0); drain();
        issue(3'd1, 16'h8000, 16'h0000, 16'h8000, 4'b0101, 0); drain();

        // mul 300*300 with ready watch and an ignored mid-busy start
        issue(3'd6, 16'd300, 16'd300, 16'h5F90, 4'b0001, 16);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            if (i == 0) start = 1'b0;
            if (i == 5) begin
                start  = 1'b1;
                alu_op = 3'd0;
                a      = 16'h1234;
                b      = 16'h1111;
            end
            if (i == 6) start = 1'b0;
            check_eq("mul_ready", {31'd0, ready}, 32'd0);
        end
        drain();
        repeat (5) @(negedge clk);

        issue(3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001, 16); drain();
        issue(3'd6, 16'd3, 16'd5, 16'd15, 4'b0000, 16); drain();

        // back-to-back, start held through DONE
        issue(3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 0);
        issue(3'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0100, 0);
        drain();

        issue(3'd5, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000, 0); drain();
        issue(3'd5, 16'h0001, 16'hFFFF, 16'h0000, 4'b1000, 0); drain();
        issue(3'd4, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 0); drain();
        issue(3'd7, 16'hABCD, 16'h1234, 16'h0000, 4'b1000, 0); drain();

        // reset 8 cycles into a multiply
        issue(3'd6, 16'd300, 16'd300, 16'h5F90, 4'b0001, 16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midmul_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (24) @(negedge clk);
        #1;
        check_eq("post_reset_done", {31'd0, done}, 32'd0);
        issue(3'd0, 16'd2, 16'd3, 16'd5, 4'b0000, 0); drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
